// File: rtl/branch_unit.sv
// Branch resolution unit: resolves RV32I conditional branches in EX, registers the
// outcome, owns a 2-bit saturating-counter BHT for fetch prediction and keeps statistics.
module branch_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic [6:0]       ID_opcode,
    input  logic [2:0]       funct,
    input  logic [XLEN-1:0]  op1,
    input  logic [XLEN-1:0]  op2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    output logic             res_valid,
    output logic             ExeBranch,
    output logic             mispredict,
    input  logic             stats_clear,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int IDX = $clog2(BHT_ENTRIES);
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [1:0]     r_bht [BHT_ENTRIES];
    logic [IDX-1:0] w_pred_idx;
    logic [IDX-1:0] w_ex_idx;
    logic           w_funct_ok;
    logic           w_taken;
    logic           w_is_branch;
    logic           w_mispredict;
    logic [1:0]     w_cnt_cur;
    logic [1:0]     w_cnt_next;
    logic           w_unused;

    // Only the index bits of the PCs matter; the rest are deliberately ignored.
    assign w_unused   = ^{pred_pc[XLEN-1:IDX+2], pred_pc[1:0], ex_pc[XLEN-1:IDX+2], ex_pc[1:0]};
    assign w_pred_idx = pred_pc[IDX+1:2];
    assign w_ex_idx   = ex_pc[IDX+1:2];
    assign pred_taken = r_bht[w_pred_idx][1];

    // Branch decode, direction compare and saturating counter next value.
    always_comb begin
        w_funct_ok = 1'b0;
        w_taken    = 1'b0;
        case (funct)
            3'b000: begin w_funct_ok = 1'b1; w_taken = (op1 == op2); end
            3'b001: begin w_funct_ok = 1'b1; w_taken = (op1 != op2); end
            3'b100: begin w_funct_ok = 1'b1; w_taken = ($signed(op1) <  $signed(op2)); end
            3'b101: begin w_funct_ok = 1'b1; w_taken = ($signed(op1) >= $signed(op2)); end
            3'b110: begin w_funct_ok = 1'b1; w_taken = (op1 <  op2); end
            3'b111: begin w_funct_ok = 1'b1; w_taken = (op1 >= op2); end
            default: begin w_funct_ok = 1'b0; w_taken = 1'b0; end
        endcase
        w_is_branch  = ex_valid && (ID_opcode == OPC_BRANCH) && w_funct_ok;
        w_mispredict = w_taken != ex_pred_taken;
        w_cnt_cur    = r_bht[w_ex_idx];
        if (w_taken) begin
            w_cnt_next = (w_cnt_cur == 2'b11) ? 2'b11 : w_cnt_cur + 2'b01;
        end else begin
            w_cnt_next = (w_cnt_cur == 2'b00) ? 2'b00 : w_cnt_cur - 2'b01;
        end
    end

    // BHT storage; all entries start weakly not taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_is_branch) begin
            r_bht[w_ex_idx] <= w_cnt_next;
        end
    end

    // Registered resolve outputs, forced low for non-branches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid  <= 1'b0;
            ExeBranch  <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            res_valid  <= w_is_branch;
            ExeBranch  <= w_is_branch && w_taken;
            mispredict <= w_is_branch && w_mispredict;
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count     <= {CNT_W{1'b0}};
            mispredict_count <= {CNT_W{1'b0}};
        end else if (stats_clear) begin
            branch_count     <= {CNT_W{1'b0}};
            mispredict_count <= {CNT_W{1'b0}};
        end else if (w_is_branch) begin
            if (branch_count != {CNT_W{1'b1}}) begin
                branch_count <= branch_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_mispredict && (mispredict_count != {CNT_W{1'b1}})) begin
                mispredict_count <= mispredict_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit with hand-computed expectations.
module tb_branch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pred_pc = 32'd0;
    logic        pred_taken, pred_taken_s;
    logic        ex_valid = 1'b0;
    logic [6:0]  ID_opcode = 7'd0;
    logic [2:0]  funct = 3'd0;
    logic [31:0] op1 = 32'd0, op2 = 32'd0, ex_pc = 32'd0;
    logic        ex_pred_taken = 1'b0;
    logic        res_valid, ExeBranch, mispredict;
    logic        res_valid_s, ExeBranch_s, mispredict_s;
    logic        stats_clear = 1'b0;
    logic [31:0] branch_count, mispredict_count;
    logic [3:0]  branch_count_s, mispredict_count_s;
    int          n_checks = 0;
    int          n_errors = 0;

    branch_unit #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ID_opcode(ID_opcode), .funct(funct), .op1(op1), .op2(op2),
        .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .res_valid(res_valid),
        .ExeBranch(ExeBranch), .mispredict(mispredict), .stats_clear(stats_clear),
        .branch_count(branch_count), .mispredict_count(mispredict_count));

    branch_unit #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(4)) u_small (
        .clk(clk), .reset(reset), .pred_pc(pred_pc), .pred_taken(pred_taken_s),
        .ex_valid(ex_valid), .ID_opcode(ID_opcode), .funct(funct), .op1(op1), .op2(op2),
        .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .res_valid(res_valid_s),
        .ExeBranch(ExeBranch_s), .mispredict(mispredict_s), .stats_clear(stats_clear),
        .branch_count(branch_count_s), .mispredict_count(mispredict_count_s));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_br(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic pr);
        ex_valid = 1'b1; ID_opcode = 7'b1100011; funct = f;
        op1 = a; op2 = b; ex_pc = pc; ex_pred_taken = pr;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic pr);
        set_br(f, a, b, pc, pr);
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic v, input logic t, input logic m);
        check({tag, "_valid"}, 32'(res_valid), 32'(v));
        check({tag, "_taken"}, 32'(ExeBranch), 32'(t));
        check({tag, "_misp"},  32'(mispredict), 32'(m));
    endtask

    initial begin
        // Reset state and prediction sweep
        #12;
        check_res("rst", 1'b0, 1'b0, 1'b0);
        check("rst_bc", branch_count, 32'd0);
        check("rst_mc", mispredict_count, 32'd0);
        for (int p = 0; p <= 32'hFC; p += 4) begin
            pred_pc = 32'(p); #1;
            check("rst_pred", 32'(pred_taken), 32'd0);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check_res("post_rst", 1'b0, 1'b0, 1'b0);

        // BEQ / BNE basics
        issue(3'b000, 32'd5, 32'd5, 32'h0, 1'b0);
        check_res("beq_eq", 1'b1, 1'b1, 1'b1);
        check("beq_eq_bc", branch_count, 32'd1);
        check("beq_eq_mc", mispredict_count, 32'd1);
        issue(3'b000, 32'd5, 32'd4, 32'h0, 1'b0);
        check_res("beq_ne", 1'b1, 1'b0, 1'b0);
        issue(3'b001, 32'd5, 32'd4, 32'h0, 1'b1);
        check_res("bne", 1'b1, 1'b1, 1'b0);

        // Signedness: -2 versus 1
        issue(3'b100, 32'hFFFFFFFE, 32'd1, 32'h8, 1'b0);
        check_res("blt", 1'b1, 1'b1, 1'b1);
        issue(3'b110, 32'hFFFFFFFE, 32'd1, 32'h8, 1'b0);
        check_res("bltu", 1'b1, 1'b0, 1'b0);
        issue(3'b101, 32'hFFFFFFFE, 32'd1, 32'h8, 1'b0);
        check_res("bge", 1'b1, 1'b0, 1'b0);
        issue(3'b111, 32'hFFFFFFFE, 32'd1, 32'h8, 1'b0);
        check_res("bgeu", 1'b1, 1'b1, 1'b1);
        check("sign_bc", branch_count, 32'd7);
        check("sign_mc", mispredict_count, 32'd3);

        // Counter saturation at 0x40, same-cycle lookup sees old value
        pred_pc = 32'h40;
        set_br(3'b000, 32'd1, 32'd1, 32'h40, 1'b1); #1;
        check("same_cycle_old", 32'(pred_taken), 32'd0);
        @(posedge clk); #1; ex_valid = 1'b0;
        check("sat_t1", 32'(pred_taken), 32'd1);
        issue(3'b000, 32'd1, 32'd1, 32'h40, 1'b1);
        issue(3'b000, 32'd1, 32'd1, 32'h40, 1'b1);
        issue(3'b000, 32'd1, 32'd1, 32'h40, 1'b1);
        check("sat_t4", 32'(pred_taken), 32'd1);
        pred_pc = 32'h140; #1;
        check("alias_140", 32'(pred_taken), 32'd1);
        pred_pc = 32'h40;
        issue(3'b000, 32'd1, 32'd2, 32'h40, 1'b0);
        check("sat_n1", 32'(pred_taken), 32'd1);
        issue(3'b000, 32'd1, 32'd2, 32'h40, 1'b0);
        check("sat_n2", 32'(pred_taken), 32'd0);
        check("sat_bc", branch_count, 32'd13);
        check("sat_mc", mispredict_count, 32'd3);

        // Non-branches leave BHT and stats alone
        pred_pc = 32'h80;
        set_br(3'b000, 32'd3, 32'd3, 32'h80, 1'b0); ID_opcode = 7'b1111111;
        @(posedge clk); #1; ex_valid = 1'b0;
        check_res("nb_opc", 1'b0, 1'b0, 1'b0);
        issue(3'b010, 32'd3, 32'd3, 32'h80, 1'b0);
        check_res("nb_f010", 1'b0, 1'b0, 1'b0);
        set_br(3'b000, 32'd3, 32'd3, 32'h80, 1'b0); ex_valid = 1'b0;
        @(posedge clk); #1;
        check_res("nb_inval", 1'b0, 1'b0, 1'b0);
        check("nb_pred", 32'(pred_taken), 32'd0);
        check("nb_bc", branch_count, 32'd13);

        // stats_clear beats a mispredicting branch
        pred_pc = 32'h40;
        stats_clear = 1'b1;
        issue(3'b000, 32'd7, 32'd7, 32'h40, 1'b0);
        stats_clear = 1'b0;
        check_res("clr", 1'b1, 1'b1, 1'b1);
        check("clr_bc", branch_count, 32'd0);
        check("clr_mc", mispredict_count, 32'd0);
        check("clr_pred", 32'(pred_taken), 32'd1);

        // Reset mid-stream clears immediately
        issue(3'b000, 32'd7, 32'd7, 32'h40, 1'b0);
        reset = 1'b1; #1;
        check_res("mid_rst", 1'b0, 1'b0, 1'b0);
        check("mid_rst_bc", branch_count, 32'd1 - 32'd1);
        check("mid_rst_pred", 32'(pred_taken), 32'd0);
        @(negedge clk); reset = 1'b0;

        // 20 back-to-back mispredicting branches, CNT_W=4 saturates at 15
        set_br(3'b000, 32'd9, 32'd9, 32'hC, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("b2b_valid", 32'(res_valid), 32'd1);
        end
        ex_valid = 1'b0;
        check("b2b_bc", branch_count, 32'd20);
        check("b2b_mc", mispredict_count, 32'd20);
        check("small_bc", 32'(branch_count_s), 32'd15);
        check("small_mc", 32'(mispredict_count_s), 32'd15);
        @(posedge clk); #1;
        check_res("b2b_idle", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised branch resolution unit for the pipelined RV32I core, replacing the purely combinational branch comparator. It resolves conditional branches in EX and registers the outcome for the EX/MEM boundary. It owns a BHT of 2-bit saturating counters that supplies fetch-stage predictions, flags mispredictions, and keeps branch and mispredict statistics.

## Interface
Parameters:
- XLEN, 32, operand and PC width
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, ≥ 2
- CNT_W, 32, width of statistics counters

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pred_pc  in  XLEN  fetch-stage PC for prediction lookup
- pred_taken  out  1  prediction for pred_pc (combinational read)
- ex_valid  in  1  EX-stage instruction valid
- ID_opcode  in  7  opcode of EX-stage instruction
- funct  in  3  funct3 of EX-stage instruction
- op1  in  XLEN  rs1 value (forwarded)
- op2  in  XLEN  rs2 value (forwarded)
- ex_pc  in  XLEN  PC of EX-stage instruction
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- res_valid  out  1  registered: a branch was resolved last cycle
- ExeBranch  out  1  registered resolved direction (1 = taken)
- mispredict  out  1  registered: resolved direction ≠ ex_pred_taken
- stats_clear  in  1  synchronous clear of statistics counters
- branch_count  out  CNT_W  resolved-branch count
- mispredict_count  out  CNT_W  misprediction count

## Operation
- Branch condition: ex_valid=1, ID_opcode=7'b1100011, funct ∈ {000,001,100,101,110,111}. Anything else is a non-branch.
- For funct values 010/011 with the branch opcode, no resolve, no update, no count.
- Direction: BEQ op1==op2; BNE !=; BLT signed <; BGE signed ≥; BLTU unsigned <; BGEU unsigned ≥. Signed compares use the full XLEN two's complement.
- BHT index: pc[IDX+1:2], IDX = log2(BHT_ENTRIES). Upper PC bits are ignored, so aliasing is permitted.
- pred_taken = MSB of counter[index(pred_pc)].
- Counter update on a branch:
  - taken: counter+1, saturating at 2'b11
  - not taken: counter−1, saturating at 2'b00
- On a branch, next cycle:
  - res_valid=1
  - ExeBranch=direction
  - mispredict=(direction≠ex_pred_taken)
- On a non-branch, next cycle: res_valid=0, ExeBranch=0, mispredict=0. ExeBranch and mispredict are never 1 while res_valid=0.
- Statistics:
  - branch_count +1 per resolved branch.
  - mispredict_count +1 per mispredict.
  - Both saturate at all-ones; they do not wrap.
  - stats_clear sets both to 0 and takes priority over increments in the same cycle.

## Timing
- Reset (async, immediate):
  - all BHT counters = 2'b01 (weakly not taken)
  - res_valid, ExeBranch, mispredict = 0
  - branch_count, mispredict_count = 0
  - pred_taken therefore reads 0 for every PC.
- Resolve latency is 1 cycle: inputs sampled at edge N, outputs valid after edge N, stable until edge N+1.
- Back-to-back branches are accepted every cycle with no stall and no ready signal.
- BHT update takes effect at the sampling edge. A same-cycle pred_pc lookup of the index being updated returns the pre-update value; the next cycle returns the new value.
- Two consecutive updates to the same index accumulate: two taken updates from 01 give 11.
- Reset asserted mid-stream discards the in-flight result. Outputs are 0 on the first edge after deassertion unless ex_valid is sampled high there.
- pred_taken is purely combinational from pred_pc and BHT state; no input-to-output path involves EX inputs.

## Test plan
- Reset, then sweep pred_pc over 0x0..0xFC (step 4) -> pred_taken=0 for all, all counters and outputs 0.
- BEQ op1=op2=5, ex_pred_taken=0 -> next cycle res_valid=1, ExeBranch=1, mispredict=1, branch_count=1, mispredict_count=1. Repeat with op2=4 -> ExeBranch=0, mispredict=0.
- Signedness at XLEN=32, op1=0xFFFFFFFE, op2=1:
  - BLT -> ExeBranch=1
  - BLTU -> ExeBranch=0
  - BGE -> 0
  - BGEU -> 1
- Counter saturation at ex_pc=0x40:
  - three taken BEQs -> pred_taken(0x40)=1 after the first; counter 11 after the third
  - fourth taken -> counter stays 11
  - two not-taken -> pred_taken=0
  - 0x140 aliases 0x40 with BHT_ENTRIES=64 -> same prediction
- Non-branches:
  - ID_opcode=7'b1111111 -> res_valid=0, counters unchanged
  - funct=010 with the branch opcode -> same
  - ex_valid=0 with a valid BEQ -> no update
- Same-cycle update/lookup on one index returns the old value. stats_clear coincident with a mispredicting branch -> both counts 0. CNT_W=4 with 20 branches -> branch_count=15. Reset asserted mid-stream -> outputs 0 immediately.
